// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int DMEM_DEPTH_DEFAULT = 101;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
  } rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - 2-way round-robin grant with last-granted register
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_q;

  // Port 0 wins when alone, or on contention when port 1 was served last.
  assign gnt[0] = req[0] & (~req[1] | (last_q == PORT_M1));
  assign gnt[1] = req[1] & ~gnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_M1;
    end else if (gnt[0]) begin
      last_q <= PORT_M0;
    end else if (gnt[1]) begin
      last_q <= PORT_M1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with tagged latency-1 responses
// Optional out-of-range checking enabled by DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          any_gnt;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          oor;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  rsp_tag_t      tag_q;

  // Requests are masked during reset so no grant can leak out combinationally.
  assign req = {m1_req, m0_req} & {2{rst_n}};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign any_gnt   = |gnt;
  assign win_we    = gnt[1] ? m1_we    : m0_we;
  assign win_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign win_wdata = gnt[1] ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign oor = any_gnt & (win_addr >= AW'(DEPTH));
`else
  localparam int unused_depth = DEPTH;
  assign oor = 1'b0;
`endif

  assign mem_we    = any_gnt & win_we & ~oor;
  assign mem_addr  = any_gnt ? win_addr  : mem_addr_q;
  assign mem_wdata = any_gnt ? win_wdata : mem_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
    end else begin
      if (any_gnt) begin
        mem_addr_q  <= win_addr;
        mem_wdata_q <= win_wdata;
      end
      tag_q.valid <= any_gnt;
      tag_q.port  <= gnt[1] ? PORT_M1 : PORT_M0;
      tag_q.err   <= oor;
    end
  end

  assign m0_rvalid = tag_q.valid & (tag_q.port == PORT_M0);
  assign m1_rvalid = tag_q.valid & (tag_q.port == PORT_M1);
  assign m0_rdata  = (m0_rvalid & ~tag_q.err) ? mem_rdata : '0;
  assign m1_rdata  = (m1_rvalid & ~tag_q.err) ? mem_rdata : '0;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign m0_err = m0_rvalid & tag_q.err;
  assign m1_err = m1_rvalid & tag_q.err;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:127] = '{default: '0};

  int vectors = 0;
  int miscompares = 0;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  always #5 clk = ~clk;

  // Write-first synchronous memory: a write returns its own data next cycle.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr[6:0]];
  end

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset state, with a request pending that must not be granted.
    m0_req = 1'b1; m0_addr = 32'd9; m0_wdata = 32'h55;
    tick; #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    chk("rst_err", {m0_err, m1_err}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    m0_req = 1'b0;
    rst_n = 1'b1;
    tick;

    // m0 write 5 then read 5.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd5; m0_wdata = 32'hDEADBEEF; #1;
    chk("wr_gnt", m0_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'd5);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick;
    m0_we = 1'b0; m0_wdata = 32'h0; #1;
    chk("wr_rvalid", m0_rvalid, 1);
    chk("wr_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_gnt", m0_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("wr_m1_rvalid", m1_rvalid, 0);
    tick;
    m0_req = 1'b0; #1;
    chk("rd_rvalid", m0_rvalid, 1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("idle_gnt", {m0_gnt, m1_gnt}, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_hold_addr", mem_addr, 32'd5);
    chk("rd_m1_rvalid", m1_rvalid, 0);
    tick;
    chk("post_rvalid", m0_rvalid, 0);
    chk("post_rdata", m0_rdata, 0);

    // Reset, then both ports read for six cycles: strict alternation from m0.
    rst_n = 1'b0; tick; rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd5;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt_m0_gnt%0d", i), m0_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_m1_gnt%0d", i), m1_gnt, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        chk($sformatf("alt_m0_rv%0d", i), m0_rvalid, (i % 2 == 1) ? 1 : 0);
        chk($sformatf("alt_m1_rv%0d", i), m1_rvalid, (i % 2 == 0) ? 1 : 0);
        chk($sformatf("alt_rdata%0d", i), m0_rdata, (i % 2 == 1) ? 32'hDEADBEEF : 32'h0);
      end
      tick;
    end
    m0_req = 1'b0; m1_req = 1'b0; #1;
    chk("alt_last_m1_rv", m1_rvalid, 1);
    chk("alt_last_m0_rv", m0_rvalid, 0);
    tick;

    // m1 write 7 and m0 read 7 together; m0 wins and sees old data.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd7; m1_wdata = 32'h12345678;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd7; #1;
    chk("cont_m0_gnt", m0_gnt, 1);
    chk("cont_m1_gnt", m1_gnt, 0);
    chk("cont_mem_we", mem_we, 0);
    chk("cont_mem_addr", mem_addr, 32'd7);
    tick;
    m0_req = 1'b0; #1;
    chk("cont_m1_gnt2", m1_gnt, 1);
    chk("cont_mem_we2", mem_we, 1);
    chk("cont_mem_wdata", mem_wdata, 32'h12345678);
    chk("cont_m0_rv", m0_rvalid, 1);
    chk("cont_m0_old", m0_rdata, 32'h0);
    tick;
    m1_req = 1'b0; m1_we = 1'b0; m0_req = 1'b1; #1;
    chk("cont_m1_rv", m1_rvalid, 1);
    chk("cont_m1_rdata", m1_rdata, 32'h12345678);
    chk("cont_m1_err", m1_err, 0);
    chk("cont_rd_gnt", m0_gnt, 1);
    tick;
    m0_req = 1'b0; #1;
    chk("cont_new_rv", m0_rvalid, 1);
    chk("cont_new_rdata", m0_rdata, 32'h12345678);
    tick;

    // Write beyond DEPTH.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd101; m0_wdata = 32'hFFFFFFFF; #1;
    chk("oor_gnt", m0_gnt, 1);
    chk("oor_mem_we", mem_we, RC ? 0 : 1);
    tick;
    m0_req = 1'b0; m0_we = 1'b0; #1;
    chk("oor_rvalid", m0_rvalid, 1);
    chk("oor_err", m0_err, RC ? 1 : 0);
    chk("oor_rdata", m0_rdata, RC ? 32'h0 : 32'hFFFFFFFF);
    tick;
    chk("oor_err_clear", m0_err, 0);

    // Grant m0 read, then reset during its response: response discarded.
    m0_req = 1'b1; m0_addr = 32'd5; #1;
    chk("rr_gnt", m0_gnt, 1);
    tick;
    m0_req = 1'b0;
    rst_n = 1'b0; #1;
    chk("rr_async_rv", m0_rvalid, 0);
    chk("rr_async_rdata", m0_rdata, 0);
    tick;
    rst_n = 1'b1; #1;
    chk("rr_rel_rv", {m0_rvalid, m1_rvalid}, 0);
    tick;
    chk("rr_rel_rv2", {m0_rvalid, m1_rvalid}, 0);
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'd5; m1_addr = 32'd5; #1;
    chk("rr_first_m0", m0_gnt, 1);
    chk("rr_first_m1", m1_gnt, 0);
    tick;
    m0_req = 1'b0; m1_req = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
